// File: rtl/exhaustive_equiv_checker.sv
`default_nettype none
// ============================================================================
// Module : exhaustive_equiv_checker
// Brief  : Sweeps every input vector into two DUTs, compares their outputs,
//          and reports pass/fail, the mismatch count and the first failing vector.
// Rev    : 1.0
// ============================================================================
module exhaustive_equiv_checker #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter int CNT_W  = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [N_OUT-1:0] i_ev_out,
    input  logic [N_OUT-1:0] i_ref_out,
    output logic [N_IN-1:0]  o_stim,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_match,
    output logic [CNT_W-1:0] o_mismatch_count,
    output logic [N_IN-1:0]  o_first_fail_vec,
    output logic             o_first_fail_vld
);

    localparam int c_SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_SCW-1:0] c_SETTLE_LAST = c_SCW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [N_IN-1:0]  r_stim,  w_stim_nxt;
    logic [c_SCW-1:0] r_cnt,   w_cnt_nxt;
    logic             r_done,  w_done_nxt;
    logic             r_pass,  w_pass_nxt;
    logic [CNT_W-1:0] r_mcnt,  w_mcnt_nxt;
    logic [N_IN-1:0]  r_ffv,   w_ffv_nxt;
    logic             r_ffvld, w_ffvld_nxt;
    logic             w_match;

    assign w_match = &(i_ev_out ~^ i_ref_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_stim  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mcnt  <= '0;
            r_ffv   <= '0;
            r_ffvld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stim  <= w_stim_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_mcnt  <= w_mcnt_nxt;
            r_ffv   <= w_ffv_nxt;
            r_ffvld <= w_ffvld_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stim_nxt  = r_stim;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_mcnt_nxt  = r_mcnt;
        w_ffv_nxt   = r_ffv;
        w_ffvld_nxt = r_ffvld;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_SETTLE;
                    w_stim_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_mcnt_nxt  = '0;
                    w_ffv_nxt   = '0;
                    w_ffvld_nxt = 1'b0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (!w_match) begin
                    if (r_mcnt != '1) begin
                        w_mcnt_nxt = r_mcnt + 1'b1;
                    end
                    if (!r_ffvld) begin
                        w_ffv_nxt   = r_stim;
                        w_ffvld_nxt = 1'b1;
                    end
                end
                // Pass must see this cycle's count update, hence w_mcnt_nxt.
                if (r_stim == '1) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_mcnt_nxt == '0);
                end else begin
                    w_stim_nxt  = r_stim + 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETTLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_stim           = r_stim;
    assign o_busy           = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_match          = w_match;
    assign o_mismatch_count = r_mcnt;
    assign o_first_fail_vec = r_ffv;
    assign o_first_fail_vld = r_ffvld;

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_equiv_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_exhaustive_equiv_checker
// Brief  : Self-checking bench for exhaustive_equiv_checker (scoreboard based).
// Rev    : 1.0
// ============================================================================
module tb_exhaustive_equiv_checker;

    localparam int N_IN        = 3;
    localparam int SETTLE      = 1;
    localparam int SWEEP_EDGES = (1 << N_IN) * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_sat = 1'b0;
    logic [0:0] ev, ref_o, ev_sat, ref_sat;

    logic [2:0] stim, ffv;
    logic       busy, done, pass, match, ffvld;
    logic [3:0] mcnt;

    logic [2:0] stim_sat, ffv_sat;
    logic       busy_sat, done_sat, pass_sat, match_sat, ffvld_sat;
    logic [1:0] mcnt_sat;

    int checks = 0;
    int errors = 0;
    int mode = 0;

    typedef struct {
        int         edge_n;
        logic       pass;
        int         cnt;
        logic [2:0] ffv;
        logic       ffvld;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic mux_ref(input logic [2:0] v);
        return v[2] ? v[1] : v[0];
    endfunction

    function automatic logic ev_model(input int m, input logic [2:0] v);
        case (m)
            1:       return (v == 3'b101) ? ~mux_ref(v) : mux_ref(v);
            2:       return 1'b0;
            3:       return ~mux_ref(v);
            default: return mux_ref(v);
        endcase
    endfunction

    assign ref_o[0]   = mux_ref(stim);
    assign ev[0]      = ev_model(mode, stim);
    assign ref_sat[0] = mux_ref(stim_sat);
    assign ev_sat[0]  = ~mux_ref(stim_sat);

    exhaustive_equiv_checker #(.N_IN(3), .N_OUT(1), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_ev_out(ev), .i_ref_out(ref_o),
        .o_stim(stim), .o_busy(busy), .o_done(done), .o_pass(pass), .o_match(match),
        .o_mismatch_count(mcnt), .o_first_fail_vec(ffv), .o_first_fail_vld(ffvld)
    );

    exhaustive_equiv_checker #(.N_IN(3), .N_OUT(1), .SETTLE(SETTLE), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_start(start_sat), .i_ev_out(ev_sat), .i_ref_out(ref_sat),
        .o_stim(stim_sat), .o_busy(busy_sat), .o_done(done_sat), .o_pass(pass_sat),
        .o_match(match_sat), .o_mismatch_count(mcnt_sat), .o_first_fail_vec(ffv_sat),
        .o_first_fail_vld(ffvld_sat)
    );

    task automatic push_expected(input int m, input int cnt_max);
        exp_t e;
        e.cnt = 0; e.ffv = '0; e.ffvld = 1'b0; e.edge_n = SWEEP_EDGES;
        for (int v = 0; v < 8; v++) begin
            if (ev_model(m, 3'(v)) != mux_ref(3'(v))) begin
                if (e.cnt < cnt_max) e.cnt++;
                if (!e.ffvld) begin
                    e.ffv   = 3'(v);
                    e.ffvld = 1'b1;
                end
            end
        end
        e.pass = (e.cnt == 0);
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({stim, busy, done, pass, mcnt, ffv, ffvld} !== '0) begin
            errors++;
            $display("FAIL %s: outputs stim=%0d busy=%0d done=%0d pass=%0d cnt=%0d ffv=%0d ffvld=%0d, expected all 0",
                     tag, stim, busy, done, pass, mcnt, ffv, ffvld);
        end
    endtask

    // Sweep with per-edge stim/busy/done/match checks; the result record is popped when done rises.
    task automatic run_sweep(input int m, input bit repulse, input string tag);
        exp_t e;
        int   j;
        int   exp_stim;
        bit   got;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        push_expected(m, 15);
        @(negedge clk);
        start = 1'b0;
        j = 0; got = 1'b0;
        while (!got && j < 200) begin
            exp_stim = (j < SWEEP_EDGES) ? j / (SETTLE + 1) : 7;
            checks++;
            if (stim !== 3'(exp_stim)) begin
                errors++;
                $display("FAIL %s stim edge %0d: got %0d expected %0d", tag, j, stim, exp_stim);
            end
            checks++;
            if (busy !== (j < SWEEP_EDGES)) begin
                errors++;
                $display("FAIL %s busy edge %0d: got %0d expected %0d", tag, j, busy, (j < SWEEP_EDGES));
            end
            checks++;
            if (match !== (ev_model(m, stim) == mux_ref(stim))) begin
                errors++;
                $display("FAIL %s match edge %0d: got %0d", tag, j, match);
            end
            if (done === 1'b1) begin
                got = 1'b1;
                e = sb.pop_front();
                checks++;
                if (j != e.edge_n) begin
                    errors++;
                    $display("FAIL %s done_edge: got %0d expected %0d", tag, j, e.edge_n);
                end
                checks++;
                if (pass !== e.pass) begin
                    errors++;
                    $display("FAIL %s pass: got %0d expected %0d", tag, pass, e.pass);
                end
                checks++;
                if (mcnt !== 4'(e.cnt)) begin
                    errors++;
                    $display("FAIL %s count: got %0d expected %0d", tag, mcnt, e.cnt);
                end
                checks++;
                if (ffvld !== e.ffvld || (e.ffvld && ffv !== e.ffv)) begin
                    errors++;
                    $display("FAIL %s first_fail: got vld=%0d vec=%0d expected vld=%0d vec=%0d",
                             tag, ffvld, ffv, e.ffvld, e.ffv);
                end
            end else begin
                start = repulse && ((j + 1 == 5) || (j + 1 == 9));
                @(negedge clk);
                j++;
            end
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done not seen after %0d edges, expected %0d", tag, j, SWEEP_EDGES);
            void'(sb.pop_front());
        end
    endtask

    task automatic test_reset();
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_pass();          run_sweep(0, 1'b0, "equal");      endtask
    task automatic test_single_fail();   run_sweep(1, 1'b0, "single_fail"); endtask
    task automatic test_stuck_at0();     run_sweep(2, 1'b0, "stuck0");     endtask
    task automatic test_start_ignored(); run_sweep(0, 1'b1, "restart_ign"); endtask

    task automatic test_back_to_back();
        run_sweep(3, 1'b0, "b2b_all_fail");
        run_sweep(0, 1'b0, "b2b_equal");
    endtask

    task automatic test_hold();
        run_sweep(1, 1'b0, "hold_sweep");
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1 || stim !== 3'd7 || mcnt !== 4'd1 || pass !== 1'b0 || ffv !== 3'b101 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold: done=%0d stim=%0d cnt=%0d pass=%0d ffv=%0d busy=%0d expected 1,7,1,0,5,0",
                     done, stim, mcnt, pass, ffv, busy);
        end
    endtask

    task automatic test_reset_mid();
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (mcnt !== 4'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: cnt=%0d busy=%0d expected 3,1", mcnt, busy);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        check_all_zero("mid_reset_held");
        rst_n = 1'b1;
        run_sweep(0, 1'b0, "after_reset");
    endtask

    task automatic test_saturate();
        exp_t e;
        int   j;
        push_expected(3, 3);
        @(negedge clk);
        start_sat = 1'b1;
        @(negedge clk);
        start_sat = 1'b0;
        j = 0;
        while (done_sat !== 1'b1 && j < 200) begin
            @(negedge clk);
            j++;
        end
        e = sb.pop_front();
        checks++;
        if (done_sat !== 1'b1 || j != e.edge_n) begin
            errors++;
            $display("FAIL sat_done: done=%0d edge=%0d expected 1 at %0d", done_sat, j, e.edge_n);
        end
        checks++;
        if (mcnt_sat !== 2'(e.cnt) || pass_sat !== e.pass) begin
            errors++;
            $display("FAIL sat_count: cnt=%0d pass=%0d expected %0d,%0d", mcnt_sat, pass_sat, e.cnt, e.pass);
        end
        checks++;
        if (ffvld_sat !== e.ffvld || ffv_sat !== e.ffv) begin
            errors++;
            $display("FAIL sat_first_fail: vld=%0d vec=%0d expected %0d,%0d", ffvld_sat, ffv_sat, e.ffvld, e.ffv);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_single_fail();
        test_stuck_at0();
        test_start_ignored();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
